// File: rtl/pa_pkg.sv
// Shared definitions for the PC sequencer: PC width, FSM encoding, default depth.
package pa_pkg;

    localparam int PC_W                = 16;
    localparam int CNT_W               = 4;
    localparam int DEFAULT_NUM_ENTRIES = 100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    typedef struct packed {
        logic            valid;
        logic            rel;
        logic [PC_W-1:0] base;
        logic [PC_W-1:0] target;
    } redir_req_t;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target resolution plus range/self-target check, purely combinational.
module pc_target_calc
    import pa_pkg::*;
#(
    parameter int NUM_ENTRIES = DEFAULT_NUM_ENTRIES
) (
    input  logic            rel_i,
    input  logic [PC_W-1:0] base_i,
    input  logic [PC_W-1:0] target_i,
    input  logic [PC_W-1:0] cur_pc_i,
    output logic [PC_W-1:0] target_o,
    output logic            fault_o
);

    localparam logic [PC_W:0] LIMIT = (PC_W+1)'(NUM_ENTRIES);

    always_comb begin
        // Relative offsets wrap modulo 2^16; no saturation.
        target_o = rel_i ? (base_i + target_i) : target_i;
        // A target equal to the current PC would look like a stall to fetch.
        fault_o  = ({1'b0, target_o} >= LIMIT) || (target_o == cur_pc_i);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: run/stall/flush/fault FSM driving registered PC and flush to fetch.
module pc_sequencer
    import pa_pkg::*;
#(
    parameter int              NUM_ENTRIES  = DEFAULT_NUM_ENTRIES,
    parameter logic [PC_W-1:0] RESET_PC     = 16'h0000,
    parameter int              FLUSH_CYCLES = 1
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            enable_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic            redirect_rel_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic [PC_W-1:0] redirect_target_i,
    output logic [PC_W-1:0] pc_o,
    output logic            flush_o,
    output logic            fault_o,
    output logic [PC_W-1:0] fault_pc_o,
    output logic [2:0]      state_o
);

    localparam logic [PC_W:0]    LIMIT      = (PC_W+1)'(NUM_ENTRIES);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              flush_q, flush_d;
    logic              fault_q, fault_d;
    logic [PC_W-1:0]   fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    redir_req_t        req;
    logic [PC_W-1:0]   tgt;
    logic              tgt_fault;
    logic [PC_W:0]     inc_w;
    logic              inc_fault;
    logic              redir_ok_state;

    assign req = '{valid:  redirect_valid_i,
                   rel:    redirect_rel_i,
                   base:   redirect_pc_i,
                   target: redirect_target_i};

    pc_target_calc #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_tgt (
        .rel_i    (req.rel),
        .base_i   (req.base),
        .target_i (req.target),
        .cur_pc_i (pc_q),
        .target_o (tgt),
        .fault_o  (tgt_fault)
    );

    assign inc_w          = {1'b0, pc_q} + {{PC_W{1'b0}}, 1'b1};
    assign inc_fault      = (inc_w >= LIMIT);
    assign redir_ok_state = (state_q == ST_RUN) || (state_q == ST_STALL) ||
                            (state_q == ST_FLUSH);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        cnt_d      = cnt_q;

        // Redirect outranks stall and enable whenever it is honoured.
        if (req.valid && redir_ok_state) begin
            if (tgt_fault) begin
                state_d    = ST_FAULT;
                fault_d    = 1'b1;
                fault_pc_d = tgt;
                cnt_d      = '0;
            end else begin
                state_d = ST_FLUSH;
                pc_d    = tgt;
                flush_d = 1'b1;
                cnt_d   = FLUSH_LOAD;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) state_d = ST_RUN;
                end
                ST_RUN, ST_STALL: begin
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                    end else if (stall_i) begin
                        state_d = ST_STALL;
                    end else if (inc_fault) begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = inc_w[PC_W-1:0];
                    end else begin
                        state_d = ST_RUN;
                        pc_d    = inc_w[PC_W-1:0];
                    end
                end
                ST_FLUSH: begin
                    // flush_o stays high for FLUSH_CYCLES edges after the redirect.
                    if (cnt_q > 1) begin
                        cnt_d   = cnt_q - 1'b1;
                        flush_d = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = enable_i ? ST_RUN : ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    fault_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc_o       = pc_q;
    assign flush_o    = flush_q;
    assign fault_o    = fault_q;
    assign fault_pc_o = fault_pc_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        stall_i;
    logic        redirect_valid_i;
    logic        redirect_rel_i;
    logic [15:0] redirect_pc_i;
    logic [15:0] redirect_target_i;
    logic [15:0] pc_o;
    logic        flush_o;
    logic        fault_o;
    logic [15:0] fault_pc_o;
    logic [2:0]  state_o;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STALL = 3'd2,
                           S_FLUSH = 3'd3, S_FAULT = 3'd4;

    pc_sequencer dut (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .enable_i          (enable_i),
        .stall_i           (stall_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_rel_i    (redirect_rel_i),
        .redirect_pc_i     (redirect_pc_i),
        .redirect_target_i (redirect_target_i),
        .pc_o              (pc_o),
        .flush_o           (flush_o),
        .fault_o           (fault_o),
        .fault_pc_o        (fault_pc_o),
        .state_o           (state_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change right after a negedge; the following posedge samples them.
    task automatic tick();
        @(negedge clock_i);
    endtask

    task automatic chk_all(input string tag, input logic [15:0] pc, input logic fl,
                           input logic [2:0] st);
        chk({tag, ".pc"}, pc_o, pc);
        chk({tag, ".flush"}, flush_o, fl);
        chk({tag, ".state"}, state_o, st);
    endtask

    task automatic redir(input logic rel, input logic [15:0] base, input logic [15:0] tg);
        redirect_valid_i  = 1'b1;
        redirect_rel_i    = rel;
        redirect_pc_i     = base;
        redirect_target_i = tg;
        tick();
        redirect_valid_i  = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        enable_i = 1'b0; stall_i = 1'b0; redirect_valid_i = 1'b0;
        redirect_rel_i = 1'b0; redirect_pc_i = '0; redirect_target_i = '0;
        tick(); tick();
        reset_i = 1'b1;
    endtask

    initial begin
        do_reset();
        chk_all("rst", 16'd0, 1'b0, S_IDLE);
        chk("rst.fault", fault_o, 1'b0);
        chk("rst.fault_pc", fault_pc_o, 16'd0);

        // Enable, free run: 0,0,1,2,3,4
        enable_i = 1'b1;
        tick(); chk_all("run0", 16'd0, 1'b0, S_RUN);
        for (int i = 1; i <= 4; i++) begin
            tick(); chk_all("run", 16'(i), 1'b0, S_RUN);
        end

        // Stall at pc=3: hold three cycles, then 4
        do_reset();
        enable_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_stall.pc", pc_o, 16'd3);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("stall", 16'd3, 1'b0, S_STALL);
        end
        stall_i = 1'b0;
        tick(); chk_all("unstall", 16'd4, 1'b0, S_RUN);

        // Run to 12, relative redirect 12 + (-2) = 10
        for (int i = 0; i < 8; i++) tick();
        chk("pre_rel.pc", pc_o, 16'd12);
        redir(1'b1, 16'd12, 16'hFFFE);
        chk_all("rel", 16'd10, 1'b1, S_FLUSH);
        tick(); chk_all("rel_end", 16'd10, 1'b0, S_RUN);
        tick(); chk_all("rel_inc", 16'd11, 1'b0, S_RUN);

        // Absolute redirect to 50 while stalled, second redirect to 20 inside flush
        stall_i = 1'b1;
        redir(1'b0, 16'd0, 16'd50);
        chk_all("abs50", 16'd50, 1'b1, S_FLUSH);
        redir(1'b0, 16'd0, 16'd20);
        chk_all("abs20", 16'd20, 1'b1, S_FLUSH);
        tick(); chk_all("abs20_end", 16'd20, 1'b0, S_RUN);
        chk("abs20.fault", fault_o, 1'b0);
        tick(); chk_all("abs20_stall", 16'd20, 1'b0, S_STALL);
        stall_i = 1'b0;
        tick(); chk_all("abs20_inc", 16'd21, 1'b0, S_RUN);

        // Disable parks in IDLE, re-enable resumes without increment on transition
        enable_i = 1'b0;
        tick(); chk_all("park", 16'd21, 1'b0, S_IDLE);
        tick(); chk_all("park2", 16'd21, 1'b0, S_IDLE);
        enable_i = 1'b1;
        tick(); chk_all("unpark", 16'd21, 1'b0, S_RUN);
        tick(); chk_all("unpark_inc", 16'd22, 1'b0, S_RUN);

        // Asynchronous reset mid-flush
        redir(1'b0, 16'd0, 16'd30);
        chk_all("pre_arst", 16'd30, 1'b1, S_FLUSH);
        #2 reset_i = 1'b0;
        #1 chk_all("arst", 16'd0, 1'b0, S_IDLE);
        tick();
        enable_i = 1'b0;
        reset_i = 1'b1;
        #1 chk_all("arst_rel", 16'd0, 1'b0, S_IDLE);
        tick(); chk_all("arst_idle", 16'd0, 1'b0, S_IDLE);

        // Redirect ignored in IDLE
        redir(1'b0, 16'd0, 16'd40);
        chk_all("idle_redir", 16'd0, 1'b0, S_IDLE);

        // Increment past the last entry faults
        enable_i = 1'b1;
        tick(); chk_all("f_run", 16'd0, 1'b0, S_RUN);
        redir(1'b0, 16'd0, 16'd98);
        chk_all("f_98", 16'd98, 1'b1, S_FLUSH);
        tick(); tick();
        chk("f_99.pc", pc_o, 16'd99);
        tick(); chk_all("f_inc", 16'd99, 1'b0, S_FAULT);
        chk("f_inc.fault", fault_o, 1'b1);
        chk("f_inc.fault_pc", fault_pc_o, 16'd100);
        redir(1'b0, 16'd0, 16'd5);
        chk_all("f_sticky", 16'd99, 1'b0, S_FAULT);
        chk("f_sticky.fault_pc", fault_pc_o, 16'd100);

        // Absolute redirect out of range
        do_reset();
        enable_i = 1'b1;
        tick();
        redir(1'b0, 16'd0, 16'd120);
        chk_all("f_120", 16'd0, 1'b0, S_FAULT);
        chk("f_120.fault", fault_o, 1'b1);
        chk("f_120.fault_pc", fault_pc_o, 16'd120);

        // Redirect to the current PC
        do_reset();
        enable_i = 1'b1;
        tick(); tick();
        chk("pre_self.pc", pc_o, 16'd1);
        redir(1'b0, 16'd0, 16'd1);
        chk_all("f_self", 16'd1, 1'b0, S_FAULT);
        chk("f_self.fault_pc", fault_pc_o, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
